sdram_port_arb: RTL and testbench

- Two-client arbiter for the single MiSTer SDRAM read/write port.
- Client A is the CPU memory interface (ROM/RAM/SRAM traffic) and has priority.
- Client B is the backup-memory (BMP) DMA engine used for HPS save/load.
- Sequences one SDRAM transaction at a time, converts the SDRAM pulse/ready protocol into a per-client REQ/ACK handshake, and guarantees client B forward progress.

---
 rtl/sdram_port_arb.sv | 167 ++++++++++++++++
 tb/tb_sdram_port_arb.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arb.sv
// Two-client arbiter for the shared SDRAM read/write port: A (CPU) has priority,
// B (backup DMA) is protected by a starvation guard. SDRAM_ARB_RR_EN selects round-robin.
module sdram_port_arb #(
  parameter int unsigned AW         = 25,
  parameter int unsigned DW         = 32,
  parameter int unsigned B_MAX_WAIT = 8
) (
  input  logic          SDRAM_CLK,
  input  logic          RESn,
  input  logic          A_REQ,
  input  logic          A_WE,
  input  logic [AW-1:0] A_ADDR,
  input  logic [DW-1:0] A_DIN,
  input  logic [3:0]    A_BE,
  output logic [DW-1:0] A_DOUT,
  output logic          A_ACK,
  input  logic          B_REQ,
  input  logic          B_WE,
  input  logic [AW-1:0] B_ADDR,
  input  logic [DW-1:0] B_DIN,
  input  logic [3:0]    B_BE,
  output logic [DW-1:0] B_DOUT,
  output logic          B_ACK,
  output logic [AW-1:0] SDRAM_WADDR,
  output logic [DW-1:0] SDRAM_DIN,
  output logic [3:0]    SDRAM_BE,
  output logic          SDRAM_WE,
  input  logic          SDRAM_WE_RDY,
  output logic          SDRAM_RD,
  input  logic          SDRAM_RD_RDY,
  output logic [AW-1:0] SDRAM_RADDR,
  input  logic [DW-1:0] SDRAM_DOUT,
  output logic          BUSY,
  output logic          GNT_B
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_ACK
  } state_t;

  state_t        state;
  logic          op_we;
  logic          pick_b_c;
  logic          pick_we_c;
  logic          grant_c;
  logic          op_rdy_c;
  logic [AW-1:0] sel_addr_c;
  logic [DW-1:0] sel_din_c;
  logic [3:0]    sel_be_c;

`ifdef SDRAM_ARB_RR_EN
  // Round-robin: on contention, the client not granted last wins.
  always_comb begin
    pick_b_c = 1'b0;
    pick_b_c = B_REQ && (!A_REQ || !GNT_B);
  end
`else
  localparam int unsigned CW = (B_MAX_WAIT > 0) ? $clog2(B_MAX_WAIT + 1) : 1;

  logic [CW-1:0] cnt;
  logic          starve_c;

  always_comb begin
    starve_c = 1'b0;
    pick_b_c = 1'b0;
    starve_c = (B_MAX_WAIT != 0) && (cnt == CW'(B_MAX_WAIT));
    pick_b_c = B_REQ && (!A_REQ || starve_c);
  end

  // Counts A grants made while B waits; saturates so B wins at the limit.
  always_ff @(posedge SDRAM_CLK or negedge RESn) begin
    if (!RESn) begin
      cnt <= '0;
    end else if (state == S_IDLE) begin
      if (!B_REQ) begin
        cnt <= '0;
      end else if (grant_c) begin
        if (pick_b_c)
          cnt <= '0;
        else if (cnt != CW'(B_MAX_WAIT))
          cnt <= cnt + CW'(1);
      end
    end
  end
`endif

  // Candidate operation and its payload; grant only when its port is idle.
  always_comb begin
    pick_we_c  = pick_b_c ? B_WE : A_WE;
    sel_addr_c = pick_b_c ? B_ADDR : A_ADDR;
    sel_din_c  = pick_b_c ? B_DIN : A_DIN;
    sel_be_c   = pick_we_c ? (pick_b_c ? B_BE : A_BE) : 4'hF;
    grant_c    = (A_REQ || B_REQ) && (pick_we_c ? SDRAM_WE_RDY : SDRAM_RD_RDY);
    op_rdy_c   = op_we ? SDRAM_WE_RDY : SDRAM_RD_RDY;
  end

  always_ff @(posedge SDRAM_CLK or negedge RESn) begin
    if (!RESn) begin
      state       <= S_IDLE;
      op_we       <= 1'b0;
      A_DOUT      <= '0;
      A_ACK       <= 1'b0;
      B_DOUT      <= '0;
      B_ACK       <= 1'b0;
      SDRAM_WADDR <= '0;
      SDRAM_RADDR <= '0;
      SDRAM_DIN   <= '0;
      SDRAM_BE    <= '0;
      SDRAM_WE    <= 1'b0;
      SDRAM_RD    <= 1'b0;
      BUSY        <= 1'b0;
      GNT_B       <= 1'b0;
    end else begin
      SDRAM_WE <= 1'b0;
      SDRAM_RD <= 1'b0;
      A_ACK    <= 1'b0;
      B_ACK    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_c) begin
            state       <= S_ISSUE;
            BUSY        <= 1'b1;
            GNT_B       <= pick_b_c;
            op_we       <= pick_we_c;
            SDRAM_WADDR <= sel_addr_c;
            SDRAM_RADDR <= sel_addr_c;
            SDRAM_DIN   <= sel_din_c;
            SDRAM_BE    <= sel_be_c;
            SDRAM_WE    <= pick_we_c;
            SDRAM_RD    <= !pick_we_c;
          end
        end
        S_ISSUE: state <= S_WAIT_BUSY;
        S_WAIT_BUSY: begin
          if (!op_rdy_c)
            state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (op_rdy_c) begin
            state <= S_ACK;
            A_ACK <= !GNT_B;
            B_ACK <= GNT_B;
            if (!op_we) begin
              if (GNT_B)
                B_DOUT <= SDRAM_DOUT;
              else
                A_DOUT <= SDRAM_DOUT;
            end
          end
        end
        S_ACK: begin
          state <= S_IDLE;
          BUSY  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arb.sv
// Directed bench for sdram_port_arb with a small SDRAM port model and event log.
module tb_sdram_port_arb;

  typedef struct {
    int          cyc;
    bit          b;
    bit          rd;
    bit          we;
    logic [24:0] raddr;
    logic [24:0] waddr;
    logic [31:0] din;
    logic [3:0]  be;
  } st_t;

  typedef struct {
    int          cyc;
    bit          a;
    bit          b;
    logic [31:0] adout;
    logic [31:0] bdout;
  } ack_t;

`ifdef SDRAM_ARB_RR_EN
  localparam int       N4   = 8;
  localparam bit [9:0] PAT4 = 10'b00_1010_1010;
`else
  localparam int       N4   = 10;
  localparam bit [9:0] PAT4 = 10'b10_0001_0000;
`endif

  logic        SDRAM_CLK;
  logic        RESn;
  logic        A_REQ, A_WE, A_ACK, B_REQ, B_WE, B_ACK;
  logic [24:0] A_ADDR, B_ADDR, SDRAM_WADDR, SDRAM_RADDR;
  logic [31:0] A_DIN, B_DIN, A_DOUT, B_DOUT, SDRAM_DIN;
  logic [3:0]  A_BE, B_BE, SDRAM_BE;
  logic        SDRAM_WE, SDRAM_RD, BUSY, GNT_B;
  logic        SDRAM_WE_RDY = 1'b1;
  logic        SDRAM_RD_RDY = 1'b1;
  logic [31:0] SDRAM_DOUT   = 32'h0;

  int          cyc = 0;
  int          rd_cnt = 0, we_cnt = 0, rd_rise_cyc = 0;
  int          rd_lat, we_lat;
  bit          rd_stall;
  logic [31:0] rd_data;
  st_t         st_q[$];
  ack_t        ack_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  sdram_port_arb #(.AW(25), .DW(32), .B_MAX_WAIT(4)) dut (
    .SDRAM_CLK(SDRAM_CLK), .RESn(RESn),
    .A_REQ(A_REQ), .A_WE(A_WE), .A_ADDR(A_ADDR), .A_DIN(A_DIN), .A_BE(A_BE),
    .A_DOUT(A_DOUT), .A_ACK(A_ACK),
    .B_REQ(B_REQ), .B_WE(B_WE), .B_ADDR(B_ADDR), .B_DIN(B_DIN), .B_BE(B_BE),
    .B_DOUT(B_DOUT), .B_ACK(B_ACK),
    .SDRAM_WADDR(SDRAM_WADDR), .SDRAM_DIN(SDRAM_DIN), .SDRAM_BE(SDRAM_BE),
    .SDRAM_WE(SDRAM_WE), .SDRAM_WE_RDY(SDRAM_WE_RDY), .SDRAM_RD(SDRAM_RD),
    .SDRAM_RD_RDY(SDRAM_RD_RDY), .SDRAM_RADDR(SDRAM_RADDR), .SDRAM_DOUT(SDRAM_DOUT),
    .BUSY(BUSY), .GNT_B(GNT_B)
  );

  initial begin
    SDRAM_CLK = 1'b0;
    forever #5 SDRAM_CLK = ~SDRAM_CLK;
  end

  // Event log plus SDRAM model: RDY drops on the strobe and returns after the latency.
  always @(negedge SDRAM_CLK) begin
    cyc++;
    if (SDRAM_RD || SDRAM_WE)
      st_q.push_back('{cyc: cyc, b: GNT_B, rd: SDRAM_RD, we: SDRAM_WE, raddr: SDRAM_RADDR,
                       waddr: SDRAM_WADDR, din: SDRAM_DIN, be: SDRAM_BE});
    if (A_ACK || B_ACK)
      ack_q.push_back('{cyc: cyc, a: A_ACK, b: B_ACK, adout: A_DOUT, bdout: B_DOUT});
    if (SDRAM_RD) begin
      SDRAM_RD_RDY = 1'b0;
      rd_cnt       = rd_lat;
      SDRAM_DOUT   = 32'h0;
    end else if (!SDRAM_RD_RDY && !rd_stall) begin
      if (rd_cnt > 1) rd_cnt--;
      else begin
        SDRAM_RD_RDY = 1'b1;
        SDRAM_DOUT   = rd_data;
        rd_rise_cyc  = cyc;
      end
    end
    if (SDRAM_WE) begin
      SDRAM_WE_RDY = 1'b0;
      we_cnt       = we_lat;
    end else if (!SDRAM_WE_RDY) begin
      if (we_cnt > 1) we_cnt--;
      else SDRAM_WE_RDY = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge SDRAM_CLK);
      #1;
    end
  endtask

  task automatic wait_for(input string tag, input bit on_ack, input int target);
    int n;
    n = 0;
    while (((on_ack ? ack_q.size() : st_q.size()) < target) && n < 400) begin
      tick(1);
      n++;
    end
    check({tag, "_timeout"}, 64'(n < 400), 64'(1));
    if (n >= 400) begin
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $fatal(1, "stopped: no progress on %s", tag);
    end
  endtask

  initial begin
    int   n0, a0;
    st_t  s;
    ack_t k;
    RESn = 1'b0;
    A_REQ = 0; A_WE = 0; A_ADDR = '0; A_DIN = '0; A_BE = '0;
    B_REQ = 0; B_WE = 0; B_ADDR = '0; B_DIN = '0; B_BE = '0;
    rd_lat = 2; we_lat = 2; rd_stall = 0; rd_data = 32'h0;
    tick(3);
    check("rst_busy", 64'(BUSY), 64'(0));
    check("rst_strobes", 64'({SDRAM_RD, SDRAM_WE, A_ACK, B_ACK, GNT_B}), 64'(0));
    check("rst_dout", 64'({A_DOUT, B_DOUT}), 64'(0));
    check("rst_bus", 64'({SDRAM_RADDR, SDRAM_BE}), 64'(0));
    RESn = 1'b1;
    tick(2);

    // A read with a 5-cycle busy window
    rd_lat = 5; rd_data = 32'hDEADBEEF;
    n0 = st_q.size(); a0 = ack_q.size();
    A_WE = 0; A_ADDR = 25'h0100004; A_DIN = 32'h1111_1111; A_BE = 4'h3; A_REQ = 1;
    @(posedge SDRAM_CLK); #1;
    check("t1_rd_latency", 64'(SDRAM_RD), 64'(1));
    check("t1_busy", 64'(BUSY), 64'(1));
    wait_for("t1_ack", 1'b1, a0 + 1);
    A_REQ = 0;
    tick(3);
    check("t1_strobes", 64'(st_q.size() - n0), 64'(1));
    check("t1_acks", 64'(ack_q.size() - a0), 64'(1));
    s = st_q[n0]; k = ack_q[a0];
    check("t1_rd_we", 64'({s.rd, s.we}), 64'(2'b10));
    check("t1_raddr", 64'(s.raddr), 64'(25'h0100004));
    check("t1_waddr", 64'(s.waddr), 64'(25'h0100004));
    check("t1_be", 64'(s.be), 64'(4'hF));
    check("t1_owner", 64'({k.a, k.b}), 64'(2'b10));
    check("t1_dout", 64'(k.adout), 64'(32'hDEADBEEF));
    check("t1_ack_latency", 64'(k.cyc - s.cyc), 64'(6));
    check("t1_dout_hold", 64'(A_DOUT), 64'(32'hDEADBEEF));

    // B write with a single enabled byte
    we_lat = 3;
    n0 = st_q.size(); a0 = ack_q.size();
    B_WE = 1; B_ADDR = 25'h0900010; B_DIN = 32'h0000_5A00; B_BE = 4'b0010; B_REQ = 1;
    wait_for("t2_ack", 1'b1, a0 + 1);
    B_REQ = 0;
    tick(3);
    check("t2_strobes", 64'(st_q.size() - n0), 64'(1));
    check("t2_acks", 64'(ack_q.size() - a0), 64'(1));
    s = st_q[n0]; k = ack_q[a0];
    check("t2_rd_we", 64'({s.rd, s.we}), 64'(2'b01));
    check("t2_waddr", 64'(s.waddr), 64'(25'h0900010));
    check("t2_din", 64'(s.din), 64'(32'h0000_5A00));
    check("t2_be", 64'(s.be), 64'(4'b0010));
    check("t2_owner", 64'({k.a, k.b}), 64'(2'b01));
    check("t2_ack_latency", 64'(k.cyc - s.cyc), 64'(4));
    check("t2_douts_kept", 64'({k.adout, k.bdout}), {32'hDEADBEEF, 32'h0});
    check("t2_gnt_b", 64'(GNT_B), 64'(1));

    // Simultaneous requests: A first, then B right after one IDLE cycle
    rd_lat = 2; rd_data = 32'hCAFEF00D; we_lat = 2;
    n0 = st_q.size(); a0 = ack_q.size();
    A_WE = 0; A_ADDR = 25'h0000040;
    B_WE = 1; B_ADDR = 25'h0000080; B_DIN = 32'hA5A5_A5A5; B_BE = 4'hF;
    A_REQ = 1; B_REQ = 1;
    wait_for("t3_ack_first", 1'b1, a0 + 1);
    A_REQ = 0;
    wait_for("t3_ack_second", 1'b1, a0 + 2);
    B_REQ = 0;
    tick(3);
    check("t3_strobes", 64'(st_q.size() - n0), 64'(2));
    check("t3_acks", 64'(ack_q.size() - a0), 64'(2));
    check("t3_first_grant_a", 64'(st_q[n0].b), 64'(0));
    check("t3_second_grant_b", 64'(st_q[n0 + 1].b), 64'(1));
    check("t3_ack_order", 64'({ack_q[a0].a, ack_q[a0 + 1].b}), 64'(2'b11));
    check("t3_gap", 64'(st_q[n0 + 1].cyc - ack_q[a0].cyc), 64'(2));
    check("t3_a_dout", 64'(ack_q[a0].adout), 64'(32'hCAFEF00D));

    // Continuous contention: grant pattern shows the guard (or round-robin)
    n0 = st_q.size(); a0 = ack_q.size();
    A_WE = 0; A_ADDR = 25'h0000100; B_WE = 1; B_ADDR = 25'h0000200;
    A_REQ = 1; B_REQ = 1;
    wait_for("t4_grants", 1'b0, n0 + N4);
    A_REQ = 0; B_REQ = 0;
    tick(20);
    for (int i = 0; i < N4; i++)
      check($sformatf("t4_grant%0d", i), 64'(st_q[n0 + i].b), 64'(PAT4[i]));
    check("t4_strobes", 64'(st_q.size() - n0), 64'(N4));
    check("t4_acks", 64'(ack_q.size() - a0), 64'(N4));

    // Reset while waiting for a stalled read; no strobe until RDY returns
    rd_lat = 3; rd_stall = 1;
    n0 = st_q.size(); a0 = ack_q.size();
    A_WE = 0; A_ADDR = 25'h0000123; A_REQ = 1;
    wait_for("t5_strobe", 1'b0, n0 + 1);
    tick(4);
    check("t5_busy_before", 64'(BUSY), 64'(1));
    RESn = 1'b0;
    #1;
    check("t5_rst_busy", 64'({BUSY, GNT_B, A_ACK, SDRAM_RD}), 64'(0));
    check("t5_rst_bus", 64'({SDRAM_RADDR, SDRAM_BE}), 64'(0));
    check("t5_rst_dout", 64'(A_DOUT), 64'(0));
    tick(2);
    RESn = 1'b1;
    tick(6);
    check("t5_no_strobe", 64'(st_q.size() - n0), 64'(1));
    check("t5_no_ack", 64'(ack_q.size() - a0), 64'(0));
    rd_data = 32'h5555_AAAA; rd_stall = 0;
    wait_for("t5_restrobe", 1'b0, n0 + 2);
    check("t5_after_rdy", 64'(st_q[n0 + 1].cyc - rd_rise_cyc), 64'(1));
    wait_for("t5_ack", 1'b1, a0 + 1);
    A_REQ = 0;
    tick(3);
    check("t5_acks", 64'(ack_q.size() - a0), 64'(1));
    check("t5_dout", 64'(ack_q[a0].adout), 64'(32'h5555_AAAA));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
